// File: rtl/elk_audio_shaper.sv
// 1-bit core sound to 16-bit signed PCM: sample strobe, volume/mute,
// one-pole low-pass and idle decay so a static line level falls to zero.
module elk_audio_shaper #(
  parameter int CLK_DIV      = 2000,
  parameter int SHIFT        = 3,
  parameter int AMP          = 12288,
  parameter int IDLE_SAMPLES = 4800
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               audio_in,
  input  logic               mute,
  input  logic [1:0]         vol,
  output logic signed [15:0] audio_out,
  output logic               sample_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (IDLE_SAMPLES > 0) ? $clog2(IDLE_SAMPLES + 1) : 1;

  localparam logic [CW-1:0]        DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]        IDLE_MAX = IW'(IDLE_SAMPLES);
  localparam logic signed [17:0]   AMP18    = 18'(AMP);
  localparam logic signed [17:0]   POS_LIM  = 18'sd32767;
  localparam logic signed [17:0]   NEG_LIM  = -18'sd32768;

  logic [1:0]         sync_q;
  logic               s_in;
  logic               prev_q;
  logic [CW-1:0]      div_cnt;
  logic [IW-1:0]      idle_cnt;

  logic               strobe_now;
  logic               chg;
  logic               idle;
  logic signed [17:0] mag;
  logic signed [17:0] target;
  logic signed [17:0] acc;
  logic signed [17:0] diff;
  logic signed [17:0] acc_next;
  logic signed [15:0] acc_sat;
  logic [IW-1:0]      idle_next;

  assign s_in = sync_q[1];

  always_comb begin
    strobe_now = (div_cnt == DIV_LAST);
    chg        = (s_in != prev_q);
    idle       = (idle_cnt == IDLE_MAX);
    mag        = AMP18 >>> vol;
    target     = '0;
    if (!(mute || (vol == 2'b11) || idle)) begin
      target = s_in ? mag : -mag;
    end

    // Accumulator is the output register itself, widened so the error and
    // the step cannot overflow before saturation.
    acc      = {{2{audio_out[15]}}, audio_out};
    diff     = target - acc;
    acc_next = acc + (diff >>> SHIFT);

    acc_sat = acc_next[15:0];
    if (acc_next > POS_LIM) begin
      acc_sat = 16'sh7fff;
    end else if (acc_next < NEG_LIM) begin
      acc_sat = -16'sh8000;
    end

    idle_next = idle_cnt;
    if (chg) begin
      idle_next = '0;
    end else if (!idle) begin
      idle_next = idle_cnt + IW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      div_cnt    <= '0;
      idle_cnt   <= '0;
      audio_out  <= '0;
      sample_stb <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], audio_in};
      div_cnt    <= strobe_now ? '0 : div_cnt + CW'(1);
      sample_stb <= strobe_now;
      if (strobe_now) begin
        prev_q    <= s_in;
        idle_cnt  <= idle_next;
        audio_out <= acc_sat;
      end
    end
  end

endmodule

// File: tb/tb_elk_audio_shaper.sv
// Bench for elk_audio_shaper: a default-parameter instance for strobe timing
// and async reset, and a fast-divider instance for the filter behaviour.
module tb_elk_audio_shaper;

  logic               clk_sys;
  logic               reset_a;
  logic               reset_b;
  logic               audio_in;
  logic               mute;
  logic [1:0]         vol;
  logic signed [15:0] out_a;
  logic signed [15:0] out_b;
  logic               stb_a;
  logic               stb_b;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       ain;
    logic [1:0] v;
    logic       m;
    int         exp;
  } vec_t;

  vec_t tbl[12];

  elk_audio_shaper dut_a (
    .clk_sys   (clk_sys),
    .reset     (reset_a),
    .audio_in  (audio_in),
    .mute      (mute),
    .vol       (vol),
    .audio_out (out_a),
    .sample_stb(stb_a)
  );

  elk_audio_shaper #(
    .CLK_DIV     (16),
    .SHIFT       (3),
    .AMP         (12288),
    .IDLE_SAMPLES(200)
  ) dut_b (
    .clk_sys   (clk_sys),
    .reset     (reset_b),
    .audio_in  (audio_in),
    .mute      (mute),
    .vol       (vol),
    .audio_out (out_b),
    .sample_stb(stb_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_stb_b();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk_sys);
      #1;
      if (stb_b) seen = 1'b1;
    end
    if (!seen) check("stb_b_timeout", 0, 1);
  endtask

  task automatic edges_to_stb_a(output int edges);
    edges = -1;
    for (int k = 1; k <= 2100; k++) begin
      @(posedge clk_sys);
      #1;
      if (stb_a) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic run_b(input int n);
    for (int k = 0; k < n; k++) wait_stb_b();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int prev_v;
    int mono;
    int maxv;
    int max_abs;
    int glitch;
    int held;

    tbl[0]  = '{1'b0, 2'd0, 1'b0, -1536};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, -2880};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, -4056};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, -5085};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, -5986};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, -6006};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, -5256};
    tbl[7]  = '{1'b0, 2'd3, 1'b0, -4599};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, -2489};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, -1794};
    tbl[10] = '{1'b0, 2'd2, 1'b0, -1954};
    tbl[11] = '{1'b0, 2'd0, 1'b0, -3246};

    reset_a  = 1'b1;
    reset_b  = 1'b1;
    audio_in = 1'b0;
    mute     = 1'b0;
    vol      = 2'd0;
    repeat (4) @(posedge clk_sys);
    #1;
    check("reset_out_a", int'(out_a), 0);
    check("reset_stb_a", int'(stb_a), 0);
    check("reset_out_b", int'(out_b), 0);
    check("reset_stb_b", int'(stb_b), 0);

    // Strobe timing and first ramp steps at the production divider.
    @(negedge clk_sys);
    reset_a = 1'b0;
    edges_to_stb_a(e);
    check("first_stb_edge", e, 2000);
    check("a_ramp_1", int'(out_a), -1536);
    @(posedge clk_sys);
    #1;
    check("stb_width", int'(stb_a), 0);
    check("hold_after_stb", int'(out_a), -1536);
    edges_to_stb_a(e);
    check("stb_period_2", e + 1, 2000);
    check("a_ramp_2", int'(out_a), -2880);
    edges_to_stb_a(e);
    check("stb_period_3", e, 2000);
    check("a_ramp_3", int'(out_a), -4056);
    edges_to_stb_a(e);
    check("stb_period_4", e, 2000);
    check("a_ramp_4", int'(out_a), -5085);

    // Async reset mid-interval, away from any clock edge.
    repeat (300) @(posedge clk_sys);
    #3;
    reset_a = 1'b1;
    #1;
    check("async_rst_out", int'(out_a), 0);
    check("async_rst_stb", int'(stb_a), 0);
    repeat (3) @(negedge clk_sys);
    reset_a = 1'b0;
    edges_to_stb_a(e);
    check("restart_first_stb", e, 2000);
    check("restart_ramp_1", int'(out_a), -1536);
    reset_a = 1'b1;

    // Directed vector table on the fast instance.
    audio_in = tbl[0].ain;
    vol      = tbl[0].v;
    mute     = tbl[0].m;
    @(negedge clk_sys);
    reset_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        audio_in = tbl[i].ain;
        vol      = tbl[i].v;
        mute     = tbl[i].m;
      end
      wait_stb_b();
      check($sformatf("vec_%0d", i), int'(out_b), tbl[i].exp);
    end

    // Low ramp from a fresh reset.
    reset_b  = 1'b1;
    audio_in = 1'b0;
    vol      = 2'd0;
    mute     = 1'b0;
    @(negedge clk_sys);
    reset_b = 1'b0;
    prev_v  = 0;
    mono    = 1;
    for (int i = 0; i < 120; i++) begin
      wait_stb_b();
      if (i == 0) check("low_ramp_1", int'(out_b), -1536);
      if (i == 1) check("low_ramp_2", int'(out_b), -2880);
      if (int'(out_b) > prev_v) mono = 0;
      prev_v = int'(out_b);
    end
    check("low_ramp_monotonic", mono, 1);
    check("low_ramp_settle", int'(out_b), -12288);

    // High ramp.
    audio_in = 1'b1;
    mono     = 1;
    maxv     = -40000;
    for (int i = 0; i < 120; i++) begin
      wait_stb_b();
      if (int'(out_b) < prev_v) mono = 0;
      if (int'(out_b) > maxv) maxv = int'(out_b);
      prev_v = int'(out_b);
    end
    check("high_ramp_monotonic", mono, 1);
    check("high_ramp_peak_le_amp", int'(maxv <= 12288), 1);
    check("high_ramp_settle_range", int'(out_b >= 12281 && out_b <= 12288), 1);

    // Idle: keep holding until idle is declared and the output decays.
    run_b(200);
    check("idle_decay_zero", int'(out_b), 0);
    audio_in = 1'b0;
    wait_stb_b();
    check("idle_exit_first", int'(out_b), 0);
    wait_stb_b();
    check("idle_exit_second", int'(out_b), -1536);

    // 1 kHz square at half volume.
    vol     = 2'd1;
    max_abs = 0;
    for (int h = 0; h < 10; h++) begin
      audio_in = ~audio_in;
      for (int k = 0; k < 24; k++) begin
        wait_stb_b();
        if (int'(out_b) > max_abs) max_abs = int'(out_b);
        if (-int'(out_b) > max_abs) max_abs = -int'(out_b);
      end
    end
    check("half_vol_bound", int'(max_abs <= 6144), 1);

    // vol=11 decays to zero from a positive level.
    vol      = 2'd0;
    audio_in = 1'b0;
    wait_stb_b();
    audio_in = 1'b1;
    run_b(40);
    check("vol_off_start_pos", int'(out_b > 0), 1);
    vol = 2'd3;
    run_b(100);
    check("vol_off_zero", int'(out_b), 0);

    // mute behaves like vol=11.
    vol      = 2'd0;
    audio_in = 1'b0;
    wait_stb_b();
    audio_in = 1'b1;
    run_b(40);
    check("mute_start_pos", int'(out_b > 0), 1);
    mute = 1'b1;
    run_b(100);
    check("mute_zero", int'(out_b), 0);
    mute = 1'b0;

    // A vol change between strobes must not touch the output until the next one.
    wait_stb_b();
    check("pre_vol_change", int'(out_b), 1536);
    held = int'(out_b);
    repeat (3) @(posedge clk_sys);
    #1;
    vol    = 2'd3;
    glitch = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_sys);
      #1;
      if (int'(out_b) != held || stb_b) glitch++;
    end
    check("no_glitch_between_stb", glitch, 0);
    wait_stb_b();
    check("post_vol_change", int'(out_b), 1344);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
